// File: rtl/acc_out_port.sv
// Accumulator output port: queues CPU OUT values in a small FIFO and drains them over valid/ready.
// Optional macro ACC_OUT_PORT_ZERO_SKIP_EN drops writes of all-zero data.
module acc_out_port #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic [WIDTH-1:0]      tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CountMax = (DEPTH_LOG2 + 1)'(Depth);

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic wr_req;
  logic push;
  logic pop;
  logic drop;

  assign full     = (count_q == CountMax);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign tx_valid = !empty;
  // Forced to zero while empty so stale storage never leaks out.
  assign tx_data  = empty ? '0 : mem_q[rd_ptr_q];

`ifdef ACC_OUT_PORT_ZERO_SKIP_EN
  assign wr_req = wr_en && (wr_data != '0);
`else
  assign wr_req = wr_en;
`endif

  assign pop  = tx_valid && tx_ready;
  assign push = wr_req && (!full || pop);
  assign drop = wr_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A dropped write outranks a clear in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
